seven_seg_mux: RTL and testbench
================================

// Module: seven_seg_mux
// PURPOSE
//   Downstream of the dec/hex digit selector. Takes the two BCD/hex nibbles and drives a
//   2-digit multiplexed 7-segment display. Each digit is time-sliced with a blanking gap
//   to prevent ghosting. Both nibbles are re-sampled together once per frame, so a displayed
//   frame never mixes old and new values.
// PARAMETERS
//   CLK_HZ         12_000_000  system clock frequency
//   REFRESH_HZ     1000        slot rate (one slot = one digit); DIV = CLK_HZ/REFRESH_HZ
//   BLANK_CYCLES   64          dead cycles at start of each slot; must satisfy 0 < BLANK_CYCLES < DIV
//   SEG_ACTIVE_LOW 1           1: seg/dp pins driven low = lit
//   DIG_ACTIVE_LOW 1           1: digit enable pins driven low = on
//   LZ_BLANK       0           1: suppress MS digit when its nibble is 0
// PORTS
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   nibbleMS   in   4  most-significant digit value, 0x0-0xF
//   nibbleLS   in   4  least-significant digit value, 0x0-0xF
//   dp_in      in   2  decimal point request, [1]=MS, [0]=LS
//   seg        out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   seg_dp     out  1  decimal point, polarity per SEG_ACTIVE_LOW
//   digit_en   out  2  [1]=MS, [0]=LS common drive, polarity per DIG_ACTIVE_LOW
//   frame_tick out  1  1-cycle pulse when the shadow nibbles are loaded
// BEHAVIOUR
//   - Clocking: one clock. Reset is synchronous, active-high; all state is registered.
//   - Reset: cnt=0, state=BLANK, dig=0 (LS), shadow regs=0, frame_tick=0.
//     All segments and both digits are driven inactive (after polarity is applied).
//   - Slot counter: cnt runs 0..DIV-1 and wraps to 0.
//     On wrap, dig toggles (LS->MS->LS).
//   - FSM, 2 states:
//       BLANK: entered at cnt==0; leaves when cnt==BLANK_CYCLES-1.
//       SHOW:  runs until cnt==DIV-1, then returns to BLANK.
//   - In BLANK, digit_en is all inactive and seg/seg_dp are all inactive.
//   - In SHOW, digit_en has one-hot bit [dig] active.
//     seg = decode(shadow[dig]); seg_dp = shadow_dp[dig].
//   - Frame load: on the cycle cnt wraps with dig==1 (a new LS slot starts), and on the
//     first cycle after reset release:
//       shadow <= {nibbleMS, nibbleLS, dp_in}; frame_tick=1 for that one cycle.
//     Inputs are ignored at all other times.
//   - Latency: a frame is 2*DIV cycles. An input change becomes visible on its first SHOW
//     cycle, BLANK_CYCLES after the next frame load.
//   - Decode (active-high internal): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//     A:77 b:7C C:39 d:5E E:79 F:71. The output is inverted when SEG_ACTIVE_LOW=1.
//   - LZ_BLANK=1 with shadow MS==0: digit_en[1] stays inactive during the MS SHOW slot.
//     Slot timing is unchanged. The LS digit is always shown, including value 0.
//   - Outputs are registered: seg/digit_en are valid one cycle after the FSM/cnt state
//     that selects them. Both change on the same edge, so there is no glitch overlap.
//   - Reset asserted mid-SHOW: on the next edge the outputs are inactive and cnt=0.
//     The shadow regs are cleared and reloaded after reset release.
//   - Widths: cnt is $clog2(DIV) bits. A DIV or BLANK_CYCLES violation is an elaboration
//     error (generate-time check).
// STRUCTURE
//   - Shared package seven_seg_pkg holds:
//       SEG_* 7-bit hex encodings (0-F, blank);
//       state localparams ST_BLANK/ST_SHOW;
//       DIG_LS=0, DIG_MS=1.
//   - Sub-module hex_to_7seg: purely combinational 4->7 decoder (active-high), reusable
//     by other display blocks.
//   - Top: slot counter + FSM + shadow regs + output polarity/register stage.
// TESTING (CLK_HZ=1000, REFRESH_HZ=100 -> DIV=10, BLANK_CYCLES=2, active-low unless stated)
//   1. Reset held 5 cycles, then released with MS=3, LS=7:
//      - outputs are all-ones (inactive) during reset;
//      - frame_tick fires once at release;
//      - seg stays blank for 2 cycles, then digit_en=2'b10 and seg=~7'h07 for 8 cycles.
//   2. Continue: at the MS slot, 2 cycles blank, then digit_en=2'b01 and seg=~7'h4F.
//      The frame repeats every 20 cycles, with frame_tick every 20 cycles.
//   3. Change LS 7->9 in the middle of the LS SHOW slot:
//      - seg stays ~7'h07 through the end of the frame;
//      - ~7'h6F appears only after the next frame_tick plus blank.
//   4. Sweep nibbles 0x0-0xF on both digits, one value per frame:
//      each SHOW slot matches the decode table; dp_in=2'b01 lights seg_dp only in LS slots.
//   5. LZ_BLANK=1, MS=0, LS=0:
//      - MS slot: digit_en stays 2'b11 for the whole slot;
//      - LS slot: shows ~7'h3F;
//      - with MS=1 the MS digit lights again from the next frame.
//   6. Assert reset for 1 cycle at cnt=5 of an MS SHOW slot:
//      - the next cycle has all outputs inactive and cnt=0;
//      - the display restarts on the LS slot with the shadow regs reloaded.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic DIG_LS = 1'b0;
    localparam logic DIG_MS = 1'b1;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder.
// Output is active-high; callers apply pin polarity.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the glyph for each hex value
    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Two-digit multiplexed seven-segment driver with per-slot blanking
// and frame-coherent shadow sampling of the digit values.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ         = 12_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] nibbleMS,
    input  logic [3:0] nibbleLS,
    input  logic [1:0] dp_in,
    output logic [6:0] seg,
    output logic       seg_dp,
    output logic [1:0] digit_en,
    output logic       frame_tick
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic          DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [1:0]    DIG_OFF   = {2{DIG_ACTIVE_LOW}};

    generate
        if (DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_cfg
            $error("seven_seg_mux: need DIV>=2 and 0<BLANK_CYCLES<DIV");
        end
    endgenerate

    logic [CW-1:0] cnt;
    state_t        state;
    state_t        state_nxt;
    logic          dig;
    logic          pend;
    logic [3:0]    sh_ms;
    logic [3:0]    sh_ls;
    logic [1:0]    sh_dp;

    logic          wrap;
    logic          load;
    logic [3:0]    cur_val;
    logic [6:0]    cur_glyph;
    logic          lit;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [1:0]    en_nxt;

    // A frame load happens on the first cycle out of reset and
    // whenever the MS slot ends, so both nibbles change together.
    assign wrap = (cnt == CNT_LAST);
    assign load = pend || (wrap && dig == DIG_MS);

    // Slot counter, digit select and shadow capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            dig        <= DIG_LS;
            pend       <= 1'b1;
            sh_ms      <= '0;
            sh_ls      <= '0;
            sh_dp      <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            dig        <= wrap ? ~dig : dig;
            pend       <= 1'b0;
            frame_tick <= load;
            if (load) begin
                sh_ms <= nibbleMS;
                sh_ls <= nibbleLS;
                sh_dp <= dp_in;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: blank gap at slot start, then show
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BLANK: if (cnt == BLK_LAST) state_nxt = ST_SHOW;
            ST_SHOW:  if (wrap) state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase
    end

    assign cur_val = (dig == DIG_MS) ? sh_ms : sh_ls;

    hex_to_7seg u_dec (
        .hex (cur_val),
        .seg (cur_glyph)
    );

    // Active-high view of what the pins should show next cycle
    always_comb begin
        lit = (state == ST_SHOW);
        if (LZ_BLANK && dig == DIG_MS && sh_ms == 4'h0) begin
            lit = 1'b0;
        end
        seg_nxt = lit ? cur_glyph : SEG_BLANK;
        dp_nxt  = lit & sh_dp[dig];
        en_nxt  = 2'b00;
        if (lit) begin
            en_nxt = (dig == DIG_MS) ? 2'b10 : 2'b01;
        end
    end

    // Output register with pin polarity applied; seg and enables
    // switch on the same edge so no ghost overlap is possible.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= SEG_OFF;
            seg_dp   <= DP_OFF;
            digit_en <= DIG_OFF;
        end else begin
            seg      <= seg_nxt ^ SEG_OFF;
            seg_dp   <= dp_nxt ^ DP_OFF;
            digit_en <= en_nxt ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux against a slot/frame
// arithmetic reference model; two instances cover LZ_BLANK=0/1.
module tb_seven_seg_mux;

    localparam int DIV = 10;
    localparam int BL  = 2;
    localparam int FR  = 2 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] nibble_ms = 4'h0;
    logic [3:0] nibble_ls = 4'h0;
    logic [1:0] dp_in = 2'b00;

    logic [6:0] seg_a;
    logic       dp_a;
    logic [1:0] en_a;
    logic       ft_a;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [1:0] en_b;
    logic       ft_b;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: t = cycles since reset release, plus shadow copy
    int         t = 0;
    logic [3:0] m_ms = 4'h0;
    logic [3:0] m_ls = 4'h0;
    logic [1:0] m_dp = 2'b00;

    logic [6:0] font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seven_seg_mux #(
        .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .nibbleMS(nibble_ms), .nibbleLS(nibble_ls), .dp_in(dp_in),
        .seg(seg_a), .seg_dp(dp_a), .digit_en(en_a), .frame_tick(ft_a)
    );

    seven_seg_mux #(
        .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .nibbleMS(nibble_ms), .nibbleLS(nibble_ls), .dp_in(dp_in),
        .seg(seg_b), .seg_dp(dp_b), .digit_en(en_b), .frame_tick(ft_b)
    );

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    endtask

    // Pin values the display shows for a cycle at frame position t
    task automatic predict(input bit lz, output logic [6:0] s,
                           output logic d, output logic [1:0] en);
        int q;
        int slot;
        int off;
        logic [3:0] v;
        bit on;
        q    = t % FR;
        slot = q / DIV;
        off  = q % DIV;
        v    = (slot == 1) ? m_ms : m_ls;
        on   = (off >= BL) && !(lz && slot == 1 && m_ms == 4'h0);
        s    = on ? ~font[v] : 7'h7F;
        d    = on ? ~m_dp[slot] : 1'b1;
        en   = on ? ((slot == 1) ? 2'b01 : 2'b10) : 2'b11;
    endtask

    // One clock: predict, advance model, then compare both DUTs
    task automatic tick();
        logic [6:0] sa;
        logic [6:0] sb;
        logic       da;
        logic       db;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       ft;
        if (reset) begin
            sa = 7'h7F; sb = 7'h7F;
            da = 1'b1;  db = 1'b1;
            ea = 2'b11; eb = 2'b11;
            ft = 1'b0;
            t = 0;
            m_ms = 4'h0; m_ls = 4'h0; m_dp = 2'b00;
        end else begin
            predict(1'b0, sa, da, ea);
            predict(1'b1, sb, db, eb);
            ft = (t == 0) || (t % FR == FR - 1);
            if (ft) begin
                m_ms = nibble_ms;
                m_ls = nibble_ls;
                m_dp = dp_in;
            end
            t++;
        end
        @(posedge clk);
        #1;
        chk("seg", seg_a, sa);
        chk("seg_dp", {6'b0, dp_a}, {6'b0, da});
        chk("digit_en", {5'b0, en_a}, {5'b0, ea});
        chk("frame_tick", {6'b0, ft_a}, {6'b0, ft});
        chk("lz_seg", seg_b, sb);
        chk("lz_seg_dp", {6'b0, dp_b}, {6'b0, db});
        chk("lz_digit_en", {5'b0, en_b}, {5'b0, eb});
        chk("lz_frame_tick", {6'b0, ft_b}, {6'b0, ft});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset with MS=3, LS=7, then two full frames
        nibble_ms = 4'h3;
        nibble_ls = 4'h7;
        dp_in     = 2'b00;
        reset     = 1'b1;
        run(5);
        reset = 1'b0;
        run(2 * FR);

        // LS change in mid LS-show must wait for the next frame
        run(5);
        nibble_ls = 4'h9;
        run(2 * FR - 5);

        // Sweep all values, LS decimal point requested
        for (int v = 0; v < 16; v++) begin
            nibble_ms = 4'(v);
            nibble_ls = 4'(15 - v);
            dp_in     = 2'b01;
            run(FR);
        end

        // Random inputs changing at random cycles
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                nibble_ms = 4'($urandom_range(0, 15));
                nibble_ls = 4'($urandom_range(0, 15));
                dp_in     = 2'($urandom_range(0, 3));
            end
            tick();
        end

        // Leading-zero blanking on the LZ instance
        nibble_ms = 4'h0;
        nibble_ls = 4'h0;
        dp_in     = 2'b00;
        run(2 * FR);
        nibble_ms = 4'h1;
        run(2 * FR);

        // One-cycle reset at cnt=5 of an MS show slot
        nibble_ms = 4'hA;
        nibble_ls = 4'h5;
        for (int i = 0; i < FR && (t % FR) != DIV + 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(2 * FR);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
